// File: rtl/frame_sequencer.sv
// Frame sequencer: streams every pixel of a frame from memory through an external
// pixel pipeline and writes the result back to the same address.
module frame_sequencer #(
  parameter int PIXEL_SIZE = 24,
  parameter int DIM_WIDTH  = 11,
  parameter int ADDR_WIDTH = 18,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [PIXEL_SIZE-1:0] rd_data,
  output logic                  pipe_en,
  output logic                  pipe_hsync,
  output logic                  pipe_vsync,
  output logic [PIXEL_SIZE-1:0] pipe_data,
  input  logic [PIXEL_SIZE-1:0] pipe_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PIXEL_SIZE-1:0] wr_data
);

  localparam int NW = 2 * DIM_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                state, state_nxt;
  logic [NW-1:0]         n_calc;
  logic                  n_bad;
  logic                  accept;
  logic                  last_rd;
  logic [DIM_WIDTH-1:0]  width_r;
  logic [DIM_WIDTH-1:0]  x;
  logic [DIM_WIDTH-1:0]  y;
  logic [ADDR_WIDTH-1:0] k;
  logic [ADDR_WIDTH-1:0] n_last;
  logic                  err_q;
  logic                  hs_p0;
  logic                  vs_p0;
  logic [LATENCY:0]      vld_p;
  logic [LATENCY:0]      last_p;
  logic [ADDR_WIDTH-1:0] addr_p [0:LATENCY];

  // Frame size is judged at full product width so oversize frames cannot alias.
  assign n_calc  = NW'(width) * NW'(height);
  assign n_bad   = (n_calc == '0) || (64'(n_calc) > (64'd1 << ADDR_WIDTH));
  assign accept  = (state == IDLE) && start && !n_bad;
  assign last_rd = (k == n_last);

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    error      = err_q;
    rd_en      = 1'b0;
    rd_addr    = '0;
    pipe_en    = vld_p[0];
    pipe_hsync = vld_p[0] & hs_p0;
    pipe_vsync = vld_p[0] & vs_p0;
    pipe_data  = vld_p[0] ? rd_data : '0;
    wr_en      = vld_p[LATENCY];
    wr_addr    = vld_p[LATENCY] ? addr_p[LATENCY] : '0;
    wr_data    = vld_p[LATENCY] ? pipe_out : '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = k;
        if (last_rd) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (vld_p[LATENCY] && last_p[LATENCY]) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      width_r <= '0;
      n_last  <= '0;
      k       <= '0;
      x       <= '0;
      y       <= '0;
      hs_p0   <= 1'b0;
      vs_p0   <= 1'b0;
      vld_p   <= '0;
      last_p  <= '0;
      for (int i = 0; i <= LATENCY; i++) addr_p[i] <= '0;
    end else begin
      state <= state_nxt;
      err_q <= (state == IDLE) && start && n_bad;
      if (accept) begin
        width_r <= width;
        n_last  <= ADDR_WIDTH'(n_calc - NW'(1));
        k       <= '0;
        x       <= '0;
        y       <= '0;
      end else if (state == RUN) begin
        k <= k + ADDR_WIDTH'(1);
        if (x == width_r - DIM_WIDTH'(1)) begin
          x <= '0;
          y <= y + DIM_WIDTH'(1);
        end else begin
          x <= x + DIM_WIDTH'(1);
        end
      end
      // Stage p0: read issued last cycle, pixel now on rd_data
      vld_p[0]  <= rd_en;
      last_p[0] <= rd_en & last_rd;
      addr_p[0] <= k;
      hs_p0     <= (x == '0);
      vs_p0     <= (x == '0) && (y == '0);
      // Stages p1..pLATENCY: align address with the pipeline return
      for (int i = 1; i <= LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

endmodule
